// File: rtl/conv_icb_arb_if.sv
// ICB link (command + response channels) between one master and one slave.
// The master side drives the command and rsp_ready; the slave side answers.
interface conv_icb_arb_if;
    logic        icb_cmd_valid;
    logic        icb_cmd_ready;
    logic [31:0] icb_cmd_addr;
    logic        icb_cmd_read;
    logic [31:0] icb_cmd_wdata;
    logic [3:0]  icb_cmd_wmask;
    logic        icb_rsp_valid;
    logic        icb_rsp_ready;
    logic [31:0] icb_rsp_rdata;

    modport master (
        output icb_cmd_valid, icb_cmd_addr, icb_cmd_read, icb_cmd_wdata, icb_cmd_wmask,
        output icb_rsp_ready,
        input  icb_cmd_ready, icb_rsp_valid, icb_rsp_rdata
    );

    modport slave (
        input  icb_cmd_valid, icb_cmd_addr, icb_cmd_read, icb_cmd_wdata, icb_cmd_wmask,
        input  icb_rsp_ready,
        output icb_cmd_ready, icb_rsp_valid, icb_rsp_rdata
    );
endinterface

// File: rtl/conv_icb_arb.sv
// Two-master ICB arbiter: round-robin command grant with lock-on-stall, in-order
// ID FIFO routing each slave response back to the master that issued it.
module conv_icb_arb #(
    parameter int unsigned OUTS_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    conv_icb_arb_if.slave                 m0,
    conv_icb_arb_if.slave                 m1,
    conv_icb_arb_if.master                s,
    output logic [$clog2(OUTS_DEPTH):0]   outs_cnt,
    output logic                          proto_err
);

    localparam int unsigned PW = $clog2(OUTS_DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(OUTS_DEPTH);

    logic                  last_gnt_q, lock_q, lock_id_q, proto_err_q;
    logic [OUTS_DEPTH-1:0] fifo_q;
    logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
    logic [PW:0]           cnt_q, cnt_d;

    logic gnt, gnt_valid, fifo_full, fifo_empty, head;
    logic push, pop;

    assign fifo_full  = (cnt_q == FULL_CNT);
    assign fifo_empty = (cnt_q == '0);
    assign head       = fifo_q[rd_ptr_q];

    // Lock holds the grant on a stalled master so its command stays stable.
    always_comb begin
        gnt = ~last_gnt_q;
        if (lock_q) begin
            gnt = lock_id_q;
        end else if (m0.icb_cmd_valid && !m1.icb_cmd_valid) begin
            gnt = 1'b0;
        end else if (m1.icb_cmd_valid && !m0.icb_cmd_valid) begin
            gnt = 1'b1;
        end
    end

    assign gnt_valid = gnt ? m1.icb_cmd_valid : m0.icb_cmd_valid;

    always_comb begin
        s.icb_cmd_valid  = gnt_valid & ~fifo_full;
        s.icb_cmd_addr   = gnt ? m1.icb_cmd_addr  : m0.icb_cmd_addr;
        s.icb_cmd_read   = gnt ? m1.icb_cmd_read  : m0.icb_cmd_read;
        s.icb_cmd_wdata  = gnt ? m1.icb_cmd_wdata : m0.icb_cmd_wdata;
        s.icb_cmd_wmask  = gnt ? m1.icb_cmd_wmask : m0.icb_cmd_wmask;
        m0.icb_cmd_ready = ~gnt & s.icb_cmd_ready & ~fifo_full;
        m1.icb_cmd_ready =  gnt & s.icb_cmd_ready & ~fifo_full;
    end

    // With nothing outstanding the slave response is drained and flagged.
    always_comb begin
        m0.icb_rsp_valid = 1'b0;
        m1.icb_rsp_valid = 1'b0;
        s.icb_rsp_ready  = 1'b1;
        if (!fifo_empty) begin
            m0.icb_rsp_valid = ~head & s.icb_rsp_valid;
            m1.icb_rsp_valid =  head & s.icb_rsp_valid;
            s.icb_rsp_ready  = head ? m1.icb_rsp_ready : m0.icb_rsp_ready;
        end
    end

    assign m0.icb_rsp_rdata = s.icb_rsp_rdata;
    assign m1.icb_rsp_rdata = s.icb_rsp_rdata;

    assign push = s.icb_cmd_valid & s.icb_cmd_ready;
    assign pop  = s.icb_rsp_valid & s.icb_rsp_ready & ~fifo_empty;

    always_comb begin
        cnt_d = cnt_q;
        unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + (PW+1)'(1);
            2'b01:   cnt_d = cnt_q - (PW+1)'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_gnt_q  <= 1'b1;
            lock_q      <= 1'b0;
            lock_id_q   <= 1'b0;
            proto_err_q <= 1'b0;
            fifo_q      <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
        end else begin
            if (push) begin
                last_gnt_q       <= gnt;
                lock_q           <= 1'b0;
                fifo_q[wr_ptr_q] <= gnt;
                wr_ptr_q         <= wr_ptr_q + PW'(1);
            end else if (gnt_valid) begin
                lock_q    <= 1'b1;
                lock_id_q <= gnt;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            if (s.icb_rsp_valid && fifo_empty) begin
                proto_err_q <= 1'b1;
            end
            cnt_q <= cnt_d;
        end
    end

    assign outs_cnt  = cnt_q;
    assign proto_err = proto_err_q;

endmodule

// File: tb/tb_conv_icb_arb.sv
// Directed bench for conv_icb_arb: reset, single master, contention, lock,
// full FIFO, response backpressure and unsolicited-response scenarios.
module tb_conv_icb_arb;

    logic       clk;
    logic       rst;
    logic [2:0] outs_cnt;
    logic       proto_err;
    int         chk_cnt;
    int         pass_cnt;

    conv_icb_arb_if m0_if ();
    conv_icb_arb_if m1_if ();
    conv_icb_arb_if s_if ();

    conv_icb_arb #(.OUTS_DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .m0        (m0_if),
        .m1        (m1_if),
        .s         (s_if),
        .outs_cnt  (outs_cnt),
        .proto_err (proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        m0_if.icb_cmd_valid = 1'b0;
        m0_if.icb_cmd_addr  = 32'h0;
        m0_if.icb_cmd_read  = 1'b1;
        m0_if.icb_cmd_wdata = 32'h0;
        m0_if.icb_cmd_wmask = 4'h0;
        m0_if.icb_rsp_ready = 1'b1;
        m1_if.icb_cmd_valid = 1'b0;
        m1_if.icb_cmd_addr  = 32'h0;
        m1_if.icb_cmd_read  = 1'b1;
        m1_if.icb_cmd_wdata = 32'h0;
        m1_if.icb_cmd_wmask = 4'h0;
        m1_if.icb_rsp_ready = 1'b1;
        s_if.icb_cmd_ready  = 1'b0;
        s_if.icb_rsp_valid  = 1'b0;
        s_if.icb_rsp_rdata  = 32'h0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        #1;
        chk_cnt++; if (s_if.icb_cmd_valid !== 1'b0) $display("FAIL rst_s_cmd_valid: got %b want 0", s_if.icb_cmd_valid); else pass_cnt++;
        chk_cnt++; if ({m1_if.icb_cmd_ready, m0_if.icb_cmd_ready} !== 2'b00) $display("FAIL rst_cmd_ready: got %b want 00", {m1_if.icb_cmd_ready, m0_if.icb_cmd_ready}); else pass_cnt++;
        chk_cnt++; if ({m1_if.icb_rsp_valid, m0_if.icb_rsp_valid} !== 2'b00) $display("FAIL rst_rsp_valid: got %b want 00", {m1_if.icb_rsp_valid, m0_if.icb_rsp_valid}); else pass_cnt++;
        chk_cnt++; if (s_if.icb_rsp_ready !== 1'b1) $display("FAIL rst_s_rsp_ready: got %b want 1", s_if.icb_rsp_ready); else pass_cnt++;
        chk_cnt++; if (outs_cnt !== 3'd0) $display("FAIL rst_outs_cnt: got %0d want 0", outs_cnt); else pass_cnt++;
        chk_cnt++; if (proto_err !== 1'b0) $display("FAIL rst_proto_err: got %b want 0", proto_err); else pass_cnt++;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_single_master();
        logic [2:0]  peak;
        logic        m1_seen;
        logic [31:0] exp_addr;
        logic [31:0] exp_data;
        apply_reset();
        peak = 3'd0;
        m1_seen = 1'b0;
        s_if.icb_cmd_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_addr = 32'h0000_2000 + 32'(4 * i);
            exp_data = 32'hD000_0000 + 32'(i);
            m0_if.icb_cmd_valid = (i < 3);
            m0_if.icb_cmd_addr  = exp_addr;
            s_if.icb_rsp_valid  = (i > 0);
            s_if.icb_rsp_rdata  = exp_data;
            #1;
            if (i < 3) begin
                chk_cnt++; if (s_if.icb_cmd_addr !== exp_addr) $display("FAIL single_addr[%0d]: got %h want %h", i, s_if.icb_cmd_addr, exp_addr); else pass_cnt++;
                chk_cnt++; if (m0_if.icb_cmd_ready !== 1'b1) $display("FAIL single_cmd_ready[%0d]: got %b want 1", i, m0_if.icb_cmd_ready); else pass_cnt++;
            end
            if (i > 0) begin
                chk_cnt++; if (m0_if.icb_rsp_valid !== 1'b1) $display("FAIL single_rsp_valid[%0d]: got %b want 1", i, m0_if.icb_rsp_valid); else pass_cnt++;
                chk_cnt++; if (m0_if.icb_rsp_rdata !== exp_data) $display("FAIL single_rdata[%0d]: got %h want %h", i, m0_if.icb_rsp_rdata, exp_data); else pass_cnt++;
            end
            if (m1_if.icb_rsp_valid) m1_seen = 1'b1;
            tick();
            if (outs_cnt > peak) peak = outs_cnt;
        end
        idle_inputs();
        chk_cnt++; if (peak !== 3'd1) $display("FAIL single_peak: got %0d want 1", peak); else pass_cnt++;
        chk_cnt++; if (m1_seen !== 1'b0) $display("FAIL single_m1_rsp: got %b want 0", m1_seen); else pass_cnt++;
        chk_cnt++; if (outs_cnt !== 3'd0) $display("FAIL single_final_cnt: got %0d want 0", outs_cnt); else pass_cnt++;
    endtask

    task automatic test_contention();
        logic [31:0] exp_addr;
        logic        exp_gnt;
        apply_reset();
        s_if.icb_cmd_ready  = 1'b1;
        m0_if.icb_cmd_valid = 1'b1;
        m1_if.icb_cmd_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_gnt = i[0];
            m0_if.icb_cmd_addr = 32'h0000_1000 + 32'(i);
            m1_if.icb_cmd_addr = 32'h0000_3000 + 32'(i);
            exp_addr = exp_gnt ? m1_if.icb_cmd_addr : m0_if.icb_cmd_addr;
            #1;
            chk_cnt++; if (s_if.icb_cmd_addr !== exp_addr) $display("FAIL cont_addr[%0d]: got %h want %h", i, s_if.icb_cmd_addr, exp_addr); else pass_cnt++;
            chk_cnt++; if ({m1_if.icb_cmd_ready, m0_if.icb_cmd_ready} !== {exp_gnt, ~exp_gnt}) $display("FAIL cont_ready[%0d]: got %b want %b", i, {m1_if.icb_cmd_ready, m0_if.icb_cmd_ready}, {exp_gnt, ~exp_gnt}); else pass_cnt++;
            tick();
        end
        m0_if.icb_cmd_valid = 1'b0;
        m1_if.icb_cmd_valid = 1'b0;
        chk_cnt++; if (outs_cnt !== 3'd4) $display("FAIL cont_cnt: got %0d want 4", outs_cnt); else pass_cnt++;
        s_if.icb_rsp_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_gnt = i[0];
            s_if.icb_rsp_rdata = 32'hA000_0000 + 32'(i);
            #1;
            chk_cnt++; if ({m1_if.icb_rsp_valid, m0_if.icb_rsp_valid} !== {exp_gnt, ~exp_gnt}) $display("FAIL cont_rsp_route[%0d]: got %b want %b", i, {m1_if.icb_rsp_valid, m0_if.icb_rsp_valid}, {exp_gnt, ~exp_gnt}); else pass_cnt++;
            tick();
        end
        idle_inputs();
        chk_cnt++; if (outs_cnt !== 3'd0) $display("FAIL cont_drained: got %0d want 0", outs_cnt); else pass_cnt++;
    endtask

    task automatic test_lock();
        apply_reset();
        // One m0 handshake first so an unlocked tie would favour m1.
        s_if.icb_cmd_ready  = 1'b1;
        m0_if.icb_cmd_valid = 1'b1;
        m0_if.icb_cmd_addr  = 32'h0000_9000;
        tick();
        s_if.icb_cmd_ready  = 1'b0;
        m0_if.icb_cmd_addr  = 32'h0000_A000;
        m1_if.icb_cmd_addr  = 32'h0000_B000;
        for (int i = 0; i < 3; i++) begin
            m1_if.icb_cmd_valid = (i > 0);
            #1;
            chk_cnt++; if (s_if.icb_cmd_addr !== 32'h0000_A000) $display("FAIL lock_addr[%0d]: got %h want 0000a000", i, s_if.icb_cmd_addr); else pass_cnt++;
            chk_cnt++; if (s_if.icb_cmd_valid !== 1'b1) $display("FAIL lock_s_valid[%0d]: got %b want 1", i, s_if.icb_cmd_valid); else pass_cnt++;
            tick();
        end
        s_if.icb_cmd_ready = 1'b1;
        #1;
        chk_cnt++; if (s_if.icb_cmd_addr !== 32'h0000_A000) $display("FAIL lock_complete_addr: got %h want 0000a000", s_if.icb_cmd_addr); else pass_cnt++;
        chk_cnt++; if ({m1_if.icb_cmd_ready, m0_if.icb_cmd_ready} !== 2'b01) $display("FAIL lock_complete_ready: got %b want 01", {m1_if.icb_cmd_ready, m0_if.icb_cmd_ready}); else pass_cnt++;
        tick();
        m0_if.icb_cmd_addr = 32'h0000_A004;
        #1;
        chk_cnt++; if (s_if.icb_cmd_addr !== 32'h0000_B000) $display("FAIL lock_next_addr: got %h want 0000b000", s_if.icb_cmd_addr); else pass_cnt++;
        chk_cnt++; if ({m1_if.icb_cmd_ready, m0_if.icb_cmd_ready} !== 2'b10) $display("FAIL lock_next_ready: got %b want 10", {m1_if.icb_cmd_ready, m0_if.icb_cmd_ready}); else pass_cnt++;
        tick();
        idle_inputs();
        chk_cnt++; if (outs_cnt !== 3'd3) $display("FAIL lock_cnt: got %0d want 3", outs_cnt); else pass_cnt++;
    endtask

    task automatic test_full_fifo();
        apply_reset();
        s_if.icb_cmd_ready  = 1'b1;
        m0_if.icb_cmd_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            m0_if.icb_cmd_addr = 32'h0000_4000 + 32'(4 * i);
            tick();
        end
        chk_cnt++; if (outs_cnt !== 3'd4) $display("FAIL full_cnt: got %0d want 4", outs_cnt); else pass_cnt++;
        #1;
        chk_cnt++; if (m0_if.icb_cmd_ready !== 1'b0) $display("FAIL full_ready: got %b want 0", m0_if.icb_cmd_ready); else pass_cnt++;
        chk_cnt++; if (s_if.icb_cmd_valid !== 1'b0) $display("FAIL full_s_valid: got %b want 0", s_if.icb_cmd_valid); else pass_cnt++;
        s_if.icb_rsp_valid = 1'b1;
        #1;
        chk_cnt++; if (m0_if.icb_cmd_ready !== 1'b0) $display("FAIL full_no_bypass: got %b want 0", m0_if.icb_cmd_ready); else pass_cnt++;
        chk_cnt++; if (m0_if.icb_rsp_valid !== 1'b1) $display("FAIL full_rsp_valid: got %b want 1", m0_if.icb_rsp_valid); else pass_cnt++;
        tick();
        s_if.icb_rsp_valid = 1'b0;
        chk_cnt++; if (outs_cnt !== 3'd3) $display("FAIL full_pop_cnt: got %0d want 3", outs_cnt); else pass_cnt++;
        #1;
        chk_cnt++; if (m0_if.icb_cmd_ready !== 1'b1) $display("FAIL full_reaccept: got %b want 1", m0_if.icb_cmd_ready); else pass_cnt++;
        tick();
        idle_inputs();
        chk_cnt++; if (outs_cnt !== 3'd4) $display("FAIL full_refill_cnt: got %0d want 4", outs_cnt); else pass_cnt++;
    endtask

    task automatic test_rsp_backpressure();
        apply_reset();
        s_if.icb_cmd_ready  = 1'b1;
        m1_if.icb_cmd_valid = 1'b1;
        tick();
        m1_if.icb_cmd_valid = 1'b0;
        m0_if.icb_cmd_valid = 1'b1;
        tick();
        m0_if.icb_cmd_valid = 1'b0;
        s_if.icb_rsp_valid  = 1'b1;
        s_if.icb_rsp_rdata  = 32'h1234_5678;
        m1_if.icb_rsp_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk_cnt++; if (s_if.icb_rsp_ready !== 1'b0) $display("FAIL bp_s_ready[%0d]: got %b want 0", i, s_if.icb_rsp_ready); else pass_cnt++;
            chk_cnt++; if ({m1_if.icb_rsp_valid, m0_if.icb_rsp_valid} !== 2'b10) $display("FAIL bp_route[%0d]: got %b want 10", i, {m1_if.icb_rsp_valid, m0_if.icb_rsp_valid}); else pass_cnt++;
            tick();
            chk_cnt++; if (outs_cnt !== 3'd2) $display("FAIL bp_hold_cnt[%0d]: got %0d want 2", i, outs_cnt); else pass_cnt++;
        end
        m1_if.icb_rsp_ready = 1'b1;
        #1;
        chk_cnt++; if (s_if.icb_rsp_ready !== 1'b1) $display("FAIL bp_release: got %b want 1", s_if.icb_rsp_ready); else pass_cnt++;
        tick();
        chk_cnt++; if (outs_cnt !== 3'd1) $display("FAIL bp_pop_cnt: got %0d want 1", outs_cnt); else pass_cnt++;
        #1;
        chk_cnt++; if ({m1_if.icb_rsp_valid, m0_if.icb_rsp_valid} !== 2'b01) $display("FAIL bp_next_route: got %b want 01", {m1_if.icb_rsp_valid, m0_if.icb_rsp_valid}); else pass_cnt++;
        tick();
        idle_inputs();
        chk_cnt++; if (outs_cnt !== 3'd0) $display("FAIL bp_final_cnt: got %0d want 0", outs_cnt); else pass_cnt++;
    endtask

    task automatic test_unsolicited();
        apply_reset();
        s_if.icb_rsp_valid = 1'b1;
        #1;
        chk_cnt++; if (s_if.icb_rsp_ready !== 1'b1) $display("FAIL unsol_drain: got %b want 1", s_if.icb_rsp_ready); else pass_cnt++;
        chk_cnt++; if ({m1_if.icb_rsp_valid, m0_if.icb_rsp_valid} !== 2'b00) $display("FAIL unsol_route: got %b want 00", {m1_if.icb_rsp_valid, m0_if.icb_rsp_valid}); else pass_cnt++;
        chk_cnt++; if (proto_err !== 1'b0) $display("FAIL unsol_err_before: got %b want 0", proto_err); else pass_cnt++;
        tick();
        s_if.icb_rsp_valid = 1'b0;
        chk_cnt++; if (proto_err !== 1'b1) $display("FAIL unsol_err_set: got %b want 1", proto_err); else pass_cnt++;
        s_if.icb_cmd_ready  = 1'b1;
        m0_if.icb_cmd_valid = 1'b1;
        tick();
        tick();
        chk_cnt++; if (proto_err !== 1'b1) $display("FAIL unsol_err_sticky: got %b want 1", proto_err); else pass_cnt++;
        chk_cnt++; if (outs_cnt !== 3'd2) $display("FAIL burst_cnt: got %0d want 2", outs_cnt); else pass_cnt++;
        #2;
        rst = 1'b1;
        #1;
        chk_cnt++; if (outs_cnt !== 3'd0) $display("FAIL midrst_cnt: got %0d want 0", outs_cnt); else pass_cnt++;
        chk_cnt++; if (proto_err !== 1'b0) $display("FAIL midrst_err: got %b want 0", proto_err); else pass_cnt++;
        idle_inputs();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        chk_cnt  = 0;
        pass_cnt = 0;
        rst      = 1'b1;
        idle_inputs();
        test_reset();
        test_single_master();
        test_contention();
        test_lock();
        test_full_fifo();
        test_rsp_backpressure();
        test_unsolicited();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
